// File: rtl/banked_mem_arb.sv
// ============================================================================
// Module      : banked_mem_arb
// Description : Round-robin multi-channel arbiter in front of a single-port
//               byte-writable memory with a fixed-latency response pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_mem_arb #(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 16,
    parameter int NUM_CH   = 2,
    parameter int READ_LAT = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [NUM_CH-1:0]                    req_valid,
    output logic [NUM_CH-1:0]                    req_ready,
    input  logic [NUM_CH-1:0]                    req_wr,
    input  logic [NUM_CH*$clog2(DEPTH)-1:0]      req_addr,
    input  logic [NUM_CH*WIDTH-1:0]              req_wdata,
    input  logic [NUM_CH*(WIDTH/8)-1:0]          req_be,
    output logic                                 rsp_valid,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rsp_ch,
    output logic                                 rsp_wr,
    output logic [WIDTH-1:0]                     rsp_data
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BE_WIDTH   = WIDTH / 8;
    localparam int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_WIDTH-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0]     gnt;
    logic                  found;
    int                    sel_idx;
    logic [CH_WIDTH-1:0]   sel_ch;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;
    logic                  accept;

    logic [READ_LAT-1:0]   vld_q;
    logic [READ_LAT-1:0]   wr_q;
    logic [CH_WIDTH-1:0]   ch_q  [READ_LAT];
    logic [WIDTH-1:0]      dat_q [READ_LAT];
    logic [WIDTH-1:0]      mem_q [DEPTH];

    // First requester at or after the pointer wins, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        found   = 1'b0;
        sel_idx = 0;
        gnt     = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                sel_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    assign req_ready = reset_n ? gnt : '0;
    assign accept    = found && reset_n;
    assign sel_ch    = CH_WIDTH'(sel_idx);
    assign sel_wr    = req_wr[sel_idx];
    assign sel_addr  = req_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[sel_idx*WIDTH +: WIDTH];
    assign sel_be    = req_be[sel_idx*BE_WIDTH +: BE_WIDTH];

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (sel_idx + 1 >= NUM_CH) ? '0 : CH_WIDTH'(sel_idx + 1);
        end
    end

    // Control pipeline is reset; the data path below is not, so the array maps to RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            vld_q <= '0;
            wr_q  <= '0;
            for (int k = 0; k < READ_LAT; k++) ch_q[k] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            vld_q[0] <= accept;
            wr_q[0]  <= sel_wr;
            ch_q[0]  <= sel_ch;
            for (int k = 1; k < READ_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                wr_q[k]  <= wr_q[k-1];
                ch_q[k]  <= ch_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && sel_wr) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (sel_be[b]) mem_q[sel_addr][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
        end
        dat_q[0] <= mem_q[sel_addr];
        for (int k = 1; k < READ_LAT; k++) dat_q[k] <= dat_q[k-1];
    end

    assign rsp_valid = vld_q[READ_LAT-1];
    assign rsp_wr    = rsp_valid && wr_q[READ_LAT-1];
    assign rsp_ch    = rsp_valid ? ch_q[READ_LAT-1] : '0;
    assign rsp_data  = (rsp_valid && !wr_q[READ_LAT-1]) ? dat_q[READ_LAT-1] : '0;

endmodule

`default_nettype wire

// File: tb/tb_banked_mem_arb.sv
// ============================================================================
// Module      : tb_banked_mem_arb
// Description : Directed scoreboard bench for banked_mem_arb (2 ch, latency 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_mem_arb;

    localparam int DEPTH    = 1024;
    localparam int WIDTH    = 16;
    localparam int NUM_CH   = 2;
    localparam int READ_LAT = 2;
    localparam int AW       = 10;
    localparam int BW       = 2;

    typedef struct {
        logic        ch;
        logic        wr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic                 clk;
    logic                 reset_n;
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH-1:0]    req_wr;
    logic [NUM_CH*AW-1:0] req_addr;
    logic [NUM_CH*WIDTH-1:0] req_wdata;
    logic [NUM_CH*BW-1:0] req_be;
    logic                 rsp_valid;
    logic [0:0]           rsp_ch;
    logic                 rsp_wr;
    logic [WIDTH-1:0]     rsp_data;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    banked_mem_arb #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_CH(NUM_CH), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_wr(rsp_wr), .rsp_data(rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rsp_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_rsp: got ch=%0d wr=%0d data=%h at cyc %0d, none expected",
                             rsp_ch, rsp_wr, rsp_data, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (rsp_ch === e.ch && rsp_wr === e.wr && rsp_data === e.data && cyc == e.cyc)
                        n_pass++;
                    else
                        $display("FAIL rsp: got ch=%0d wr=%0d data=%h cyc=%0d, want ch=%0d wr=%0d data=%h cyc=%0d",
                                 rsp_ch, rsp_wr, rsp_data, cyc, e.ch, e.wr, e.data, e.cyc);
                end
            end else begin
                n_checks++;
                if (rsp_ch === 1'b0 && rsp_wr === 1'b0 && rsp_data === 16'h0) n_pass++;
                else $display("FAIL idle_rsp_zero: got ch=%0d wr=%0d data=%h, want all 0",
                              rsp_ch, rsp_wr, rsp_data);
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    exp_t e;
                    e = q.pop_front();
                    n_checks++;
                    $display("FAIL missing_rsp: got rsp_valid=0 at cyc %0d, want ch=%0d wr=%0d data=%h",
                             cyc, e.ch, e.wr, e.data);
                end
            end
        end
    end

    task automatic set_req(input int ch, input logic wr, input logic [AW-1:0] addr,
                           input logic [15:0] d, input logic [1:0] be);
        req_valid[ch]          = 1'b1;
        req_wr[ch]             = wr;
        req_addr[ch*AW +: AW]  = addr;
        req_wdata[ch*16 +: 16] = d;
        req_be[ch*BW +: BW]    = be;
    endtask

    task automatic clr_req(input int ch);
        req_valid[ch]          = 1'b0;
        req_wr[ch]             = 1'b0;
        req_addr[ch*AW +: AW]  = '0;
        req_wdata[ch*16 +: 16] = '0;
        req_be[ch*BW +: BW]    = '0;
    endtask

    // Called at a falling edge; checks the grant and queues the expected response.
    task automatic tick(input logic [1:0] exp_rdy, input logic [15:0] rexp);
        #1;
        n_checks++;
        if (req_ready === exp_rdy) n_pass++;
        else $display("FAIL grant: got req_ready=%b, want %b at cyc %0d", req_ready, exp_rdy, cyc);
        if (exp_rdy != 2'b00) begin
            exp_t e;
            e.ch   = exp_rdy[1];
            e.wr   = req_wr[exp_rdy[1]];
            e.data = e.wr ? 16'h0 : rexp;
            e.cyc  = cyc + READ_LAT;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        @(negedge clk);
        mon_en = 1'b1;
        // Requests presented during reset are never granted.
        set_req(0, 1'b1, 10'd7, 16'hDEAD, 2'b11);
        set_req(1, 1'b1, 10'd8, 16'hDEAD, 2'b11);
        tick(2'b00, 16'h0);
        tick(2'b00, 16'h0);
        clr_req(0); clr_req(1);
        reset_n = 1'b1;
        tick(2'b00, 16'h0);

        // Write then read back.
        set_req(0, 1'b1, 10'd5, 16'hBEEF, 2'b11); tick(2'b01, 16'h0);
        set_req(0, 1'b0, 10'd5, 16'h0, 2'b00);    tick(2'b01, 16'hBEEF);
        clr_req(0); tick(2'b00, 16'h0); tick(2'b00, 16'h0);

        // Byte-enable merge.
        set_req(0, 1'b1, 10'd9, 16'h1234, 2'b11); tick(2'b01, 16'h0);
        set_req(0, 1'b1, 10'd9, 16'hAB00, 2'b10); tick(2'b01, 16'h0);
        set_req(0, 1'b0, 10'd9, 16'h0, 2'b00);    tick(2'b01, 16'hAB34);
        clr_req(0);
        // Zero byte enables: acknowledged but memory untouched.
        set_req(1, 1'b1, 10'd9, 16'hFFFF, 2'b00); tick(2'b10, 16'h0);
        clr_req(1);
        set_req(0, 1'b0, 10'd9, 16'h0, 2'b00);    tick(2'b01, 16'hAB34);
        clr_req(0);
        set_req(1, 1'b0, 10'd5, 16'h0, 2'b00);    tick(2'b10, 16'hBEEF);
        clr_req(1); tick(2'b00, 16'h0);

        // Fairness: both channels busy for 8 cycles, pointer starts at 0.
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, AW'(32 + (i + 1) / 2), 16'hA000 + 16'((i + 1) / 2), 2'b11);
            set_req(1, 1'b1, AW'(48 + i / 2),       16'hB000 + 16'(i / 2),       2'b11);
            tick((i % 2 == 0) ? 2'b01 : 2'b10, 16'h0);
        end
        clr_req(0);
        set_req(1, 1'b0, 10'd51, 16'h0, 2'b00); tick(2'b10, 16'hB003);
        clr_req(1);
        set_req(0, 1'b0, 10'd34, 16'h0, 2'b00); tick(2'b01, 16'hA002);
        clr_req(0);

        // Write-then-read coherence at the top address, back to back.
        set_req(0, 1'b1, 10'd1023, 16'h0F0F, 2'b11); tick(2'b01, 16'h0);
        set_req(0, 1'b0, 10'd1023, 16'h0, 2'b00);    tick(2'b01, 16'h0F0F);
        clr_req(0);

        // Idle: no grants, pointer holds at 1 so ch1 wins next.
        tick(2'b00, 16'h0); tick(2'b00, 16'h0); tick(2'b00, 16'h0);
        set_req(0, 1'b0, 10'd9, 16'h0, 2'b00);
        set_req(1, 1'b0, 10'd5, 16'h0, 2'b00);
        tick(2'b10, 16'hBEEF);
        clr_req(1);
        tick(2'b01, 16'hAB34);
        clr_req(0); tick(2'b00, 16'h0); tick(2'b00, 16'h0);

        // Reset mid-flight: the accepted read must never respond.
        set_req(0, 1'b0, 10'd5, 16'h0, 2'b00); tick(2'b01, 16'hBEEF);
        #2;
        reset_n = 1'b0;
        q.delete();
        set_req(1, 1'b0, 10'd5, 16'h0, 2'b00);
        tick(2'b00, 16'h0);
        tick(2'b00, 16'h0);
        reset_n = 1'b1;
        // Pointer is back at 0, so ch0 wins over ch1.
        set_req(0, 1'b0, 10'd9, 16'h0, 2'b00);
        tick(2'b01, 16'hAB34);
        clr_req(0);
        tick(2'b10, 16'hBEEF);
        clr_req(1);
        for (int i = 0; i < 5; i++) tick(2'b00, 16'h0);

        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d outstanding responses, want 0", q.size());

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
